// File: rtl/branch_predictor_pkg.sv
// Core-wide branch definitions: compare-op encodings, 2-bit counter states and helpers.
// Shared by the decoder, the branch compare unit and the fetch-side predictor.
package branch_predictor_pkg;

    localparam int unsigned BP_IDX_W = 6;
    localparam int unsigned BP_XLEN  = 32;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned BHT_W    = 2;

    localparam logic [OP_W-1:0] CMP_BEQ  = 3'b000;
    localparam logic [OP_W-1:0] CMP_BNE  = 3'b001;
    localparam logic [OP_W-1:0] CMP_BLT  = 3'b010;
    localparam logic [OP_W-1:0] CMP_BGE  = 3'b011;
    localparam logic [OP_W-1:0] CMP_BLTU = 3'b100;
    localparam logic [OP_W-1:0] CMP_BGEU = 3'b101;

    localparam logic [BHT_W-1:0] BHT_SNT = 2'b00;
    localparam logic [BHT_W-1:0] BHT_WNT = 2'b01;
    localparam logic [BHT_W-1:0] BHT_WT  = 2'b10;
    localparam logic [BHT_W-1:0] BHT_ST  = 2'b11;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bp_state_e;

    function automatic logic is_valid_cmp_op(input logic [OP_W-1:0] op);
        return (op <= CMP_BGEU);
    endfunction

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [BHT_W-1:0] bht_next(input logic [BHT_W-1:0] cur,
                                                  input logic             taken);
        logic [BHT_W-1:0] nxt;
        nxt = cur;
        if (taken && (cur != BHT_ST))
            nxt = cur + BHT_W'(1);
        else if (!taken && (cur != BHT_SNT))
            nxt = cur - BHT_W'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute facing bundle of the branch predictor: predict request/response,
// resolved-branch update, mispredict pulse and perf counters.
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic            o_ready;

    logic            i_pred_valid;
    logic [XLEN-1:0] i_pred_pc;
    logic            o_pred_valid;
    logic [XLEN-1:0] o_pred_pc;
    logic            o_pred_taken;

    logic            i_upd_valid;
    logic [XLEN-1:0] i_upd_pc;
    logic [2:0]      i_upd_cmp_op;
    logic            i_upd_taken;
    logic            i_upd_pred_taken;

    logic            o_mispredict;
    logic [31:0]     o_branch_cnt;
    logic [31:0]     o_mispred_cnt;

    modport master (
        input  o_ready,
        output i_pred_valid, i_pred_pc,
        input  o_pred_valid, o_pred_pc, o_pred_taken,
        output i_upd_valid, i_upd_pc, i_upd_cmp_op, i_upd_taken, i_upd_pred_taken,
        input  o_mispredict, o_branch_cnt, o_mispred_cnt
    );

    modport slave (
        output o_ready,
        input  i_pred_valid, i_pred_pc,
        output o_pred_valid, o_pred_pc, o_pred_taken,
        input  i_upd_valid, i_upd_pc, i_upd_cmp_op, i_upd_taken, i_upd_pred_taken,
        output o_mispredict, o_branch_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_bht_ram.sv
// Flop-array branch history table: combinational reads, one clocked write port.
// Reads see the pre-write contents, so a same-cycle read/write is read-first.
module branch_predictor_bht_ram
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = BP_IDX_W
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_pred_idx,
    output logic [BHT_W-1:0] o_pred_data,
    input  logic [IDX_W-1:0] i_upd_idx,
    output logic [BHT_W-1:0] o_upd_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [BHT_W-1:0] i_wdata
);
    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [BHT_W-1:0] r_mem [DEPTH];

    // No reset: contents are established by the controller's init sweep.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_pred_data = r_mem[i_pred_idx];
    assign o_upd_data  = r_mem[i_upd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side direction predictor: PC-indexed 2-bit saturating counters trained by
// resolved branches, with mispredict pulse and branch/mispredict perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = BP_IDX_W,
    parameter int unsigned XLEN  = BP_XLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int unsigned DEPTH = 2 ** IDX_W;

    bp_state_e        r_state;
    logic [IDX_W-1:0] r_sweep_idx;
    logic             r_ready;

    logic             r_pred_valid;
    logic [XLEN-1:0]  r_pred_pc;
    logic             r_pred_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [BHT_W-1:0] w_pred_cnt;
    logic [BHT_W-1:0] w_upd_cnt;
    logic             w_pred_acc;
    logic             w_upd_acc;
    logic             w_upd_miss;
    logic             w_init;
    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [BHT_W-1:0] w_wdata;

    assign w_pred_idx = bp.i_pred_pc[IDX_W+1:2];
    assign w_upd_idx  = bp.i_upd_pc[IDX_W+1:2];

    assign w_pred_acc = bp.i_pred_valid && r_ready;
    assign w_upd_acc  = bp.i_upd_valid && r_ready && is_valid_cmp_op(bp.i_upd_cmp_op);
    assign w_upd_miss = w_upd_acc && (bp.i_upd_taken != bp.i_upd_pred_taken);

    // Sweep owns the write port during INIT; training writes only happen in RUN.
    assign w_init  = (r_state == S_INIT);
    assign w_we    = w_init || w_upd_acc;
    assign w_waddr = w_init ? r_sweep_idx : w_upd_idx;
    assign w_wdata = w_init ? BHT_WNT : bht_next(w_upd_cnt, bp.i_upd_taken);

    branch_predictor_bht_ram #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .i_pred_idx  (w_pred_idx),
        .o_pred_data (w_pred_cnt),
        .i_upd_idx   (w_upd_idx),
        .o_upd_data  (w_upd_cnt),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata)
    );

    // Init sweep then RUN until the next reset; ready rises with the first RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_sweep_idx <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_sweep_idx <= r_sweep_idx + IDX_W'(1);
                    if (r_sweep_idx == IDX_W'(DEPTH - 1)) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_INIT;
                    r_sweep_idx <= '0;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid <= 1'b0;
            r_pred_pc    <= '0;
            r_pred_taken <= 1'b0;
        end else begin
            r_pred_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_pred_pc    <= bp.i_pred_pc;
                r_pred_taken <= w_pred_cnt[BHT_W-1];
            end
        end
    end

    // Perf counters wrap naturally at 2^32; mispredict count moves with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_mispredict <= w_upd_miss;
            if (w_upd_acc)
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_upd_miss)
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign bp.o_ready       = r_ready;
    assign bp.o_pred_valid  = r_pred_valid;
    assign bp.o_pred_pc     = r_pred_pc;
    assign bp.o_pred_taken  = r_pred_taken;
    assign bp.o_mispredict  = r_mispredict;
    assign bp.o_branch_cnt  = r_branch_cnt;
    assign bp.o_mispred_cnt = r_mispred_cnt;

    logic w_unused;
    assign w_unused = &{1'b0,
                        bp.i_pred_pc[XLEN-1:IDX_W+2], bp.i_pred_pc[1:0],
                        bp.i_upd_pc[XLEN-1:IDX_W+2],  bp.i_upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: init sweep timing, training, read-first
// collisions, invalid ops, and reset during the sweep.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    branch_predictor_if #(.XLEN(32)) bp_if ();

    branch_predictor #(
        .IDX_W (6),
        .XLEN  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp_if.i_pred_valid     = 1'b0;
        bp_if.i_pred_pc        = '0;
        bp_if.i_upd_valid      = 1'b0;
        bp_if.i_upd_pc         = '0;
        bp_if.i_upd_cmp_op     = CMP_BEQ;
        bp_if.i_upd_taken      = 1'b0;
        bp_if.i_upd_pred_taken = 1'b0;
    endtask

    task automatic predict(input string tag, input logic [31:0] pc, input logic exp_taken);
        bp_if.i_pred_valid = 1'b1;
        bp_if.i_pred_pc    = pc;
        tick();
        bp_if.i_pred_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(bp_if.o_pred_valid), 32'd1);
        check_eq({tag, "_pc"},    bp_if.o_pred_pc,         pc);
        check_eq({tag, "_taken"}, 32'(bp_if.o_pred_taken), 32'(exp_taken));
    endtask

    task automatic update(input string tag, input logic [31:0] pc, input logic [2:0] op,
                          input logic taken, input logic pred, input logic exp_misp);
        bp_if.i_upd_valid      = 1'b1;
        bp_if.i_upd_pc         = pc;
        bp_if.i_upd_cmp_op     = op;
        bp_if.i_upd_taken      = taken;
        bp_if.i_upd_pred_taken = pred;
        tick();
        bp_if.i_upd_valid = 1'b0;
        check_eq({tag, "_misp"}, 32'(bp_if.o_mispredict), 32'(exp_misp));
    endtask

    task automatic check_counts(input string tag, input logic [31:0] br, input logic [31:0] mp);
        check_eq({tag, "_branch_cnt"},  bp_if.o_branch_cnt,  br);
        check_eq({tag, "_mispred_cnt"}, bp_if.o_mispred_cnt, mp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        repeat (3) tick();

        check_eq("rst_ready",      32'(bp_if.o_ready),      32'd0);
        check_eq("rst_pred_valid", 32'(bp_if.o_pred_valid), 32'd0);
        check_eq("rst_pred_taken", 32'(bp_if.o_pred_taken), 32'd0);
        check_eq("rst_pred_pc",    bp_if.o_pred_pc,         32'd0);
        check_eq("rst_misp",       32'(bp_if.o_mispredict), 32'd0);
        check_counts("rst", 32'd0, 32'd0);

        // Requests during the sweep must be dropped.
        rst_n                  = 1'b1;
        bp_if.i_pred_valid     = 1'b1;
        bp_if.i_pred_pc        = 32'h40;
        bp_if.i_upd_valid      = 1'b1;
        bp_if.i_upd_pc         = 32'h40;
        bp_if.i_upd_taken      = 1'b1;
        bp_if.i_upd_pred_taken = 1'b0;
        tick();
        idle_inputs();
        check_eq("init_pred_valid", 32'(bp_if.o_pred_valid), 32'd0);
        check_eq("init_misp",       32'(bp_if.o_mispredict), 32'd0);
        repeat (62) tick();
        check_eq("init_ready_63", 32'(bp_if.o_ready), 32'd0);
        tick();
        check_eq("init_ready_64", 32'(bp_if.o_ready), 32'd1);
        check_counts("init", 32'd0, 32'd0);

        predict("p100", 32'h100, 1'b0);
        predict("p40_init", 32'h40, 1'b0);

        // Train 0x40 to ST with realistic predicted directions.
        update("u40_a", 32'h40, CMP_BEQ, 1'b1, 1'b0, 1'b1);
        update("u40_b", 32'h40, CMP_BEQ, 1'b1, 1'b1, 1'b0);
        update("u40_c", 32'h40, CMP_BEQ, 1'b1, 1'b1, 1'b0);
        check_counts("u40", 32'd3, 32'd1);
        predict("p40_st", 32'h40, 1'b1);

        for (int i = 0; i < 4; i++)
            update($sformatf("u80_%0d", i), 32'h80, CMP_BLTU, 1'b0, 1'b1, 1'b1);
        check_counts("u80", 32'd7, 32'd5);
        predict("p80_snt", 32'h80, 1'b0);
        check_eq("misp_cleared", 32'(bp_if.o_mispredict), 32'd0);

        update("u20_train", 32'h20, CMP_BNE, 1'b1, 1'b0, 1'b1);
        bp_if.i_pred_valid     = 1'b1;
        bp_if.i_pred_pc        = 32'h20;
        bp_if.i_upd_valid      = 1'b1;
        bp_if.i_upd_pc         = 32'h20;
        bp_if.i_upd_cmp_op     = CMP_BNE;
        bp_if.i_upd_taken      = 1'b1;
        bp_if.i_upd_pred_taken = 1'b0;
        tick();
        idle_inputs();
        check_eq("coll_pred_taken", 32'(bp_if.o_pred_taken), 32'd1);
        check_eq("coll_pred_valid", 32'(bp_if.o_pred_valid), 32'd1);
        check_eq("coll_misp",       32'(bp_if.o_mispredict), 32'd1);
        predict("p20_st", 32'h20, 1'b1);
        update("u20_nt1", 32'h20, CMP_BNE, 1'b0, 1'b1, 1'b1);
        predict("p20_wt", 32'h20, 1'b1);
        update("u20_nt2", 32'h20, CMP_BNE, 1'b0, 1'b1, 1'b1);
        predict("p20_wnt", 32'h20, 1'b0);
        check_counts("u20", 32'd11, 32'd9);

        update("u40_op110", 32'h40, 3'b110, 1'b0, 1'b1, 1'b0);
        update("u40_op111", 32'h40, 3'b111, 1'b0, 1'b1, 1'b0);
        check_counts("badop", 32'd11, 32'd9);
        predict("p40_badop", 32'h40, 1'b1);

        // Reset while running clears outputs without waiting for a clock.
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready",      32'(bp_if.o_ready),      32'd0);
        check_eq("arst_pred_taken", 32'(bp_if.o_pred_taken), 32'd0);
        check_counts("arst", 32'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        check_eq("sweep_rst_ready", 32'(bp_if.o_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (63) tick();
        check_eq("resweep_ready_63", 32'(bp_if.o_ready), 32'd0);
        tick();
        check_eq("resweep_ready_64", 32'(bp_if.o_ready), 32'd1);
        predict("p40_reinit", 32'h40, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
